// File: rtl/seq_shift_sub_divider.sv
// ---------------------------------------------------------------------------
// seq_shift_sub_divider
// Multi-cycle restoring (shift-subtract) unsigned divider. Each clock produces
// one quotient bit, so a nonzero-divisor operation takes DW iterations after
// the load edge. Companion to the sequential shift-add multiplier. It trades
// latency for a tiny datapath: one VW+1 bit subtractor and a few registers.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start        operation request, only looked at while idle
//   dividend     DW-bit unsigned dividend, captured when start is accepted
//   divisor      VW-bit unsigned divisor, captured when start is accepted
//   busy         high from the accepting edge until the result is valid
//   done         one-cycle pulse marking quotient/remainder valid
//   quotient     DW-bit result, held until the next completion
//   remainder    VW-bit result, held until the next completion
//   div_by_zero  set when the last completed operation had divisor == 0
// ---------------------------------------------------------------------------
module seq_shift_sub_divider #(
   parameter int DW = 16,
   parameter int VW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_by_zero
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;
   localparam logic [CW-1:0] LAST = CW'(DW - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      ZERO = 2'd2
   } state_t;

   state_t        state;
   state_t        state_next;

   logic [VW:0]   r_reg;
   logic [DW-1:0] q_reg;
   logic [VW-1:0] d_reg;
   logic [CW-1:0] cnt;

   logic [VW:0]   r_shift;
   logic [VW+1:0] diff;
   logic          fits;
   logic [VW:0]   r_step;
   logic [DW-1:0] q_step;
   logic          last_iter;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. A zero divisor skips the iteration loop entirely and
   // reports the saturated result from the single ZERO cycle.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_next = (divisor != '0) ? CALC : ZERO;
            end
         end
         CALC: begin
            if (last_iter) begin
               state_next = IDLE;
            end
         end
         ZERO: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // One restoring step. The Q MSB is shifted into R; the top bit of R is
   // only ever set if the partial remainder overflowed VW bits, in which case
   // the shifted value is certainly larger than D, so the subtraction is
   // taken regardless of the borrow out of the low VW+1 bits.
   always_comb begin
      r_shift   = {r_reg[VW-1:0], q_reg[DW-1]};
      diff      = {1'b0, r_shift} - {2'b00, d_reg};
      fits      = r_reg[VW] | ~diff[VW+1];
      r_step    = fits ? diff[VW:0] : r_shift;
      q_step    = {q_reg[DW-2:0], fits};
      last_iter = (cnt == LAST);
   end

   // Datapath and result registers. The dividend is captured into Q even for
   // a zero divisor because the ZERO state reports its low bits as remainder.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_reg       <= '0;
         q_reg       <= '0;
         d_reg       <= '0;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  q_reg <= dividend;
                  d_reg <= divisor;
                  r_reg <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            CALC: begin
               r_reg <= r_step;
               q_reg <= q_step;
               cnt   <= cnt + 1'b1;
               if (last_iter) begin
                  quotient    <= q_step;
                  remainder   <= r_step[VW-1:0];
                  div_by_zero <= 1'b0;
                  done        <= 1'b1;
                  busy        <= 1'b0;
               end
            end
            ZERO: begin
               quotient    <= '1;
               remainder   <= q_reg[VW-1:0];
               div_by_zero <= 1'b1;
               done        <= 1'b1;
               busy        <= 1'b0;
            end
            default: begin
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
